mem_access_ctrl: RTL and testbench

Multicycle load/store sequencer between the core control unit and the 64-bit doubleword-addressed data memory. It aligns load data, drives the load extender (`select`/`inSignal`, returning `outSignal`), and performs read-modify-write merges for sub-doubleword stores. It also flags misaligned or illegal accesses and memory timeouts, returning one response per accepted request.

---
 rtl/mem_access_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Brief    : Multicycle load/store sequencer for a 64-bit doubleword memory.
//             Aligns load data for the external extender, merges sub-dword
//             stores with read-modify-write, and faults on misaligned,
//             illegal or timed-out accesses. One response per request.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic [2:0]  ext_sel,
    output logic [63:0] ext_in,
    input  logic [63:0] ext_out,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_fault
);

    localparam int             c_CW      = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EXT  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_is_store;
    logic [2:0]      r_off;
    logic [63:0]     r_wdata;
    logic [c_CW-1:0] r_cnt;
    logic            r_req_ready;
    logic [63:0]     r_mem_addr;
    logic            r_mem_rd;
    logic            r_mem_wr;
    logic [63:0]     r_mem_wdata;
    logic [2:0]      r_ext_sel;
    logic [63:0]     r_ext_in;
    logic            r_resp_valid;
    logic [63:0]     r_resp_data;
    logic            r_resp_fault;

    logic            w_illegal;
    logic            w_misaligned;
    logic [5:0]      w_shamt;
    logic [63:0]     w_mask_base;
    logic [63:0]     w_mask;
    logic [63:0]     w_merged;
    logic [c_CW-1:0] w_cnt_next;
    logic            w_timeout;

    // Accept-time legality: stores have no unsigned forms, 111 is unused for loads;
    // natural alignment is required for every access size.
    always_comb begin
        w_illegal    = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   w_misaligned = (req_addr[2:0] != 3'b000);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Byte-lane mask for sub-dword stores and the read-modify-write merge.
    always_comb begin
        w_shamt = {r_off, 3'b000};
        case (r_ext_sel[1:0])
            2'b00:   w_mask_base = 64'h0000_0000_0000_00FF;
            2'b01:   w_mask_base = 64'h0000_0000_0000_FFFF;
            2'b10:   w_mask_base = 64'h0000_0000_FFFF_FFFF;
            default: w_mask_base = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w_mask     = w_mask_base << w_shamt;
        w_merged   = (mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
        w_cnt_next = r_cnt + 1'b1;
        w_timeout  = (w_cnt_next == c_TIMEOUT);
    end

    // Sequencer: state, wait counter and every registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_is_store   <= 1'b0;
            r_off        <= 3'd0;
            r_wdata      <= 64'd0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_mem_addr   <= 64'd0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wdata  <= 64'd0;
            r_ext_sel    <= 3'd0;
            r_ext_in     <= 64'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 64'd0;
            r_resp_fault <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_ext_sel   <= req_funct3;
                        r_mem_addr  <= {req_addr[63:3], 3'b000};
                        r_off       <= req_addr[2:0];
                        r_wdata     <= req_wdata;
                        r_is_store  <= req_is_store;
                        r_cnt       <= '0;
                        if (w_illegal || w_misaligned) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= 64'd0;
                            r_resp_fault <= 1'b1;
                        end else if (req_is_store && (req_funct3[1:0] == 2'b11)) begin
                            r_state     <= S_WR;
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state  <= S_RD;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_mem_rd <= 1'b0;
                        r_cnt    <= '0;
                        if (r_is_store) begin
                            r_mem_wdata <= w_merged;
                            r_mem_wr    <= 1'b1;
                            r_state     <= S_WR;
                        end else begin
                            r_ext_in <= mem_rdata >> w_shamt;
                            r_state  <= S_EXT;
                        end
                    end else if (w_timeout) begin
                        r_mem_rd     <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= 64'd0;
                        r_resp_fault <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_EXT: begin
                    r_resp_data  <= ext_out;
                    r_resp_fault <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_WR: begin
                    if (mem_ready) begin
                        r_mem_wr     <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= 64'd0;
                        r_resp_fault <= 1'b0;
                    end else if (w_timeout) begin
                        r_mem_wr     <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= 64'd0;
                        r_resp_fault <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_rd    <= 1'b0;
                    r_mem_wr    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_wdata  = r_mem_wdata;
    assign ext_sel    = r_ext_sel;
    assign ext_in     = r_ext_in;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_fault = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Brief    : Directed bench for mem_access_ctrl with a byte-level reference
//             model, a waitable memory responder and a load extender.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic [2:0]  ext_sel;
    logic [63:0] ext_in;
    logic [63:0] ext_out;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_fault;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ext_sel(ext_sel), .ext_in(ext_in), .ext_out(ext_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Load extender stand-in: sign/zero extension selected by funct3.
    always_comb begin
        case (ext_sel)
            3'b000:  ext_out = {{56{ext_in[7]}},  ext_in[7:0]};
            3'b001:  ext_out = {{48{ext_in[15]}}, ext_in[15:0]};
            3'b010:  ext_out = {{32{ext_in[31]}}, ext_in[31:0]};
            3'b100:  ext_out = {56'd0, ext_in[7:0]};
            3'b101:  ext_out = {48'd0, ext_in[15:0]};
            3'b110:  ext_out = {32'd0, ext_in[31:0]};
            default: ext_out = ext_in;
        endcase
    end

    // Memory seen by the DUT and the reference image kept by the model.
    logic [63:0] mem_arr [0:63];
    logic [63:0] ref_mem [0:63];
    assign mem_rdata = mem_arr[mem_addr[8:3]];

    always @(posedge clk) begin
        if (mem_wr && mem_ready) mem_arr[mem_addr[8:3]] = mem_wdata;
    end

    // Responder: each strobe phase sees wait_n low cycles before mem_ready.
    int wait_n = 0;
    int rd_run = 0;
    int wr_run = 0;
    always @(negedge clk) begin
        if (mem_rd) rd_run = rd_run + 1; else rd_run = 0;
        if (mem_wr) wr_run = wr_run + 1; else wr_run = 0;
        mem_ready = (mem_rd && (rd_run > wait_n)) || (mem_wr && (wr_run > wait_n));
    end

    // Expected transaction, filled in by predict().
    bit          e_fault;
    bit          e_load;
    logic [2:0]  e_f3;
    logic [63:0] e_data;
    logic [63:0] e_ext_in;
    logic [63:0] e_maddr;
    logic [63:0] e_dword;
    int          e_idx;
    int          e_lat;
    int          e_rd;
    int          e_wr;

    task automatic predict(input bit st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int w);
        int          n;
        int          off;
        bit          bad;
        logic [63:0] dw;
        logic [63:0] sh;
        logic [7:0]  fill;
        n        = 1 << f3[1:0];
        off      = int'(a[2:0]);
        e_idx    = int'(a[8:3]);
        dw       = ref_mem[e_idx];
        e_f3     = f3;
        e_maddr  = {a[63:3], 3'b000};
        e_load   = !st;
        e_dword  = dw;
        e_ext_in = 64'd0;
        e_fault  = 1'b0;
        e_data   = 64'd0;
        e_rd     = 0;
        e_wr     = 0;
        bad      = st ? (f3 >= 3'd4) : (f3 == 3'd7);
        if ((off % n) != 0) bad = 1'b1;
        if (bad) begin
            e_fault = 1'b1;
            e_lat   = 1;
        end else if (w >= TIMEOUT) begin
            e_fault = 1'b1;
            e_lat   = TIMEOUT + 1;
            if (st && n == 8) e_wr = TIMEOUT; else e_rd = TIMEOUT;
        end else if (!st) begin
            sh       = dw >> (8 * off);
            e_ext_in = sh;
            fill     = (!f3[2] && sh[8*n-1]) ? 8'hFF : 8'h00;
            for (int i = 0; i < 8; i++)
                e_data[8*i +: 8] = (i < n) ? sh[8*i +: 8] : fill;
            e_lat = 3 + w;
            e_rd  = w + 1;
        end else if (n == 8) begin
            e_dword = wd;
            e_lat   = 2 + w;
            e_wr    = w + 1;
        end else begin
            for (int i = 0; i < n; i++)
                dw[8*(off+i) +: 8] = wd[8*i +: 8];
            e_dword = dw;
            e_lat   = 3 + 2 * w;
            e_rd    = w + 1;
            e_wr    = w + 1;
        end
    endtask

    // Per-cycle compare against the expected transaction.
    bit tracking = 1'b0;
    int cyc = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;
    always @(negedge clk) begin
        if (tracking) begin
            cyc++;
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            if (mem_rd || mem_wr) chk64("mem_addr", mem_addr, e_maddr);
            chk1("resp_valid timing", resp_valid, cyc == e_lat);
            chk1("req_ready busy", req_ready, 1'b0);
            if (cyc == e_lat) begin
                chk64("resp_data", resp_data, e_data);
                chk1("resp_fault", resp_fault, e_fault);
                chk64("ext_sel", {61'd0, ext_sel}, {61'd0, e_f3});
                if (e_load && !e_fault) chk64("ext_in", ext_in, e_ext_in);
            end
        end
    end

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int w);
        predict(st, f3, a, wd, w);
        wait_n = w;
        @(negedge clk);
        chk1("req_ready idle", req_ready, 1'b1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        // Keep a conflicting request asserted while busy; it must be ignored.
        req_is_store = ~st;
        req_funct3   = 3'b011;
        req_addr     = 64'h1F8;
        req_wdata    = 64'hDEAD_BEEF_0BAD_F00D;
        cyc = 0; rd_cyc = 0; wr_cyc = 0;
        tracking = 1'b1;
        repeat (e_lat) @(posedge clk);
        #1;
        tracking  = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk1("resp_valid single pulse", resp_valid, 1'b0);
        chk1("req_ready after resp", req_ready, 1'b1);
        chkint("mem_rd cycles", rd_cyc, e_rd);
        chkint("mem_wr cycles", wr_cyc, e_wr);
        chk64("memory dword", mem_arr[e_idx], e_dword);
        ref_mem[e_idx] = e_dword;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = {8{8'(i)}};
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[32] = 64'h8877_6655_4433_2211;
        ref_mem[32] = 64'h8877_6655_4433_2211;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1 ("reset req_ready",  req_ready,  1'b1);
        chk1 ("reset mem_rd",     mem_rd,     1'b0);
        chk1 ("reset mem_wr",     mem_wr,     1'b0);
        chk64("reset mem_addr",   mem_addr,   64'd0);
        chk64("reset mem_wdata",  mem_wdata,  64'd0);
        chk64("reset ext_sel",    {61'd0, ext_sel}, 64'd0);
        chk64("reset ext_in",     ext_in,     64'd0);
        chk1 ("reset resp_valid", resp_valid, 1'b0);
        chk64("reset resp_data",  resp_data,  64'd0);
        chk1 ("reset resp_fault", resp_fault, 1'b0);
        reset = 1'b1;

        // Loads from the preloaded dword at 0x100.
        do_req(1'b0, 3'b000, 64'h107, 64'd0, 0);
        chk64("lb 0x107 literal", resp_data, 64'hFFFF_FFFF_FFFF_FF88);
        do_req(1'b0, 3'b100, 64'h107, 64'd0, 0);
        chk64("lbu 0x107 literal", resp_data, 64'h0000_0000_0000_0088);
        do_req(1'b0, 3'b010, 64'h104, 64'd0, 0);
        chk64("lw 0x104 literal", resp_data, 64'hFFFF_FFFF_8877_6655);
        do_req(1'b0, 3'b110, 64'h104, 64'd0, 0);
        chk64("lwu 0x104 literal", resp_data, 64'h0000_0000_8877_6655);
        do_req(1'b0, 3'b011, 64'h100, 64'd0, 0);
        chk64("ld 0x100 literal", resp_data, 64'h8877_6655_4433_2211);
        do_req(1'b0, 3'b001, 64'h106, 64'd0, 0);
        do_req(1'b0, 3'b101, 64'h102, 64'd0, 0);
        chk64("lhu 0x102 literal", resp_data, 64'h0000_0000_0000_4433);

        // Stores: halfword read-modify-write, then a full doubleword write.
        do_req(1'b1, 3'b001, 64'h102, 64'h1234_BEEF, 0);
        chk64("sh merge literal", mem_arr[32], 64'h8877_6655_BEEF_2211);
        do_req(1'b1, 3'b011, 64'h100, 64'hA5, 0);
        chk64("sd literal", mem_arr[32], 64'h0000_0000_0000_00A5);

        // Faults: misaligned and illegal encodings.
        do_req(1'b0, 3'b010, 64'h102, 64'd0, 0);
        chk1("lw 0x102 fault literal", resp_fault, 1'b1);
        do_req(1'b1, 3'b011, 64'h101, 64'h55, 0);
        do_req(1'b0, 3'b111, 64'h100, 64'd0, 0);
        do_req(1'b1, 3'b100, 64'h100, 64'h66, 0);
        do_req(1'b0, 3'b001, 64'h101, 64'd0, 0);

        // Wait states.
        do_req(1'b0, 3'b011, 64'h100, 64'd0, 2);
        do_req(1'b1, 3'b000, 64'h103, 64'h77, 1);
        chk64("sb wait literal", mem_arr[32], 64'h0000_0000_7700_00A5);
        do_req(1'b1, 3'b010, 64'h10C, 64'hCAFE_F00D, 3);

        // Timeout on the read phase of a byte store.
        do_req(1'b1, 3'b000, 64'h108, 64'hEE, 1000);
        chk1("timeout fault literal", resp_fault, 1'b1);

        // Reset in the write phase abandons the access.
        wait_n = 1000;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'b011;
        req_addr     = 64'h110;
        req_wdata    = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk1("mem_wr before reset", mem_wr, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk1 ("mem_wr after reset",     mem_wr,     1'b0);
        chk1 ("req_ready after reset",  req_ready,  1'b1);
        chk1 ("resp_valid after reset", resp_valid, 1'b0);
        chk1 ("resp_fault after reset", resp_fault, 1'b0);
        chk64("mem_addr after reset",   mem_addr,   64'd0);
        reset  = 1'b1;
        wait_n = 0;
        repeat (4) begin
            @(negedge clk);
            chk1("no resp after reset", resp_valid, 1'b0);
        end
        chk64("aborted sd no write", mem_arr[34], ref_mem[34]);

        do_req(1'b0, 3'b011, 64'h100, 64'd0, 0);
        chk64("ld after reset literal", resp_data, 64'h0000_0000_7700_00A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
